// File: rtl/czonotope_prune_pkg.sv
// Shared types, sizes and helpers for the constrained-zonotope compaction stage.
// Sizes are fixed here so the interface and the datapath always agree.
package czonotope_pkg;

    localparam int NMAX       = 3;
    localparam int NGMAX      = 15;
    localparam int NCMAX      = 12;
    localparam int DATA_WIDTH = 32;

    localparam int PW_N = $clog2(NMAX + 1);
    localparam int PW_G = $clog2(NGMAX + 1);
    localparam int PW_C = $clog2(NCMAX + 1);

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL  = 2'd1,
        ROW  = 2'd2,
        DONE = 2'd3
    } prune_state_t;

    // +0 and -0 are both zero; the sign bit is ignored
    function automatic logic is_fp_zero(input logic [DATA_WIDTH-1:0] w);
        return (w[DATA_WIDTH-2:0] == '0);
    endfunction

endpackage

// File: rtl/czonotope_prune_if.sv
// Constrained zonotope bundle: centre, generators, constraint matrix/vector and sizes.
interface czonotope_if;
    import czonotope_pkg::*;

    word_t            c [NMAX];
    word_t            G [NMAX][NGMAX];
    word_t            A [NCMAX][NGMAX];
    word_t            b [NCMAX];
    logic [PW_N-1:0]  n;
    logic [PW_G-1:0]  ng;
    logic [PW_C-1:0]  nc;

    modport master (output c, G, A, b, n, ng, nc);
    modport slave  (input  c, G, A, b, n, ng, nc);
endinterface

// File: rtl/czonotope_prune.sv
// Removes all-zero generator columns and all-zero constraint rows from a
// constrained zonotope, one column then one row per cycle, and repacks it densely.
module czonotope_prune
    import czonotope_pkg::*;
(
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          start_i,
    czonotope_if.slave    Z,
    czonotope_if.master   OUT,
    output logic          busy_o,
    output logic          valid_o,
    output logic          empty_o
);

    prune_state_t     state_reg, state_next;
    logic [PW_N-1:0]  n_reg;
    logic [PW_G-1:0]  ng_reg, j_reg, wp_reg;
    logic [PW_C-1:0]  nc_reg, i_reg, rp_reg;
    logic             empty_reg;

    word_t            c_reg [NMAX];
    word_t            g_reg [NMAX][NGMAX];
    word_t            a_reg [NCMAX][NGMAX];
    word_t            b_reg [NCMAX];

    logic [NMAX-1:0]  g_col_zero;
    logic [NCMAX-1:0] a_col_zero;
    logic [NGMAX-1:0] row_el_zero;
    logic             col_dead, row_zero, b_zero;

    // Zero reductions only look inside the live extent of the source/compacted set
    genvar gi, gj;
    generate
        for (gi = 0; gi < NMAX; gi++) begin : g_gcol
            assign g_col_zero[gi] = (PW_N'(gi) >= n_reg) || is_fp_zero(Z.G[gi][j_reg]);
        end
        for (gi = 0; gi < NCMAX; gi++) begin : g_acol
            assign a_col_zero[gi] = (PW_C'(gi) >= nc_reg) || is_fp_zero(Z.A[gi][j_reg]);
        end
        for (gj = 0; gj < NGMAX; gj++) begin : g_arow
            assign row_el_zero[gj] = (PW_G'(gj) >= wp_reg) || is_fp_zero(a_reg[i_reg][gj]);
        end
    endgenerate

    assign col_dead = (&g_col_zero) & (&a_col_zero);
    assign row_zero = &row_el_zero;
    assign b_zero   = is_fp_zero(Z.b[i_reg]);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    if (Z.ng != '0)      state_next = COL;
                    else if (Z.nc != '0) state_next = ROW;
                    else                 state_next = DONE;
                end
            end
            COL: begin
                if (j_reg == ng_reg - PW_G'(1)) begin
                    state_next = (nc_reg != '0) ? ROW : DONE;
                end
            end
            ROW: begin
                if (i_reg == nc_reg - PW_C'(1)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state_reg != IDLE);
        valid_o = (state_reg == DONE);
    end

    // Copy datapath; row compaction is in place because rp never passes i
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            n_reg     <= '0;
            ng_reg    <= '0;
            nc_reg    <= '0;
            j_reg     <= '0;
            i_reg     <= '0;
            wp_reg    <= '0;
            rp_reg    <= '0;
            empty_reg <= 1'b0;
            for (int r = 0; r < NMAX; r++) c_reg[r] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        n_reg     <= Z.n;
                        ng_reg    <= Z.ng;
                        nc_reg    <= Z.nc;
                        j_reg     <= '0;
                        i_reg     <= '0;
                        wp_reg    <= '0;
                        rp_reg    <= '0;
                        empty_reg <= 1'b0;
                        for (int r = 0; r < NMAX; r++) begin
                            c_reg[r] <= (PW_N'(r) < Z.n) ? Z.c[r] : '0;
                        end
                    end
                end
                COL: begin
                    if (!col_dead) begin
                        for (int r = 0; r < NMAX; r++)  g_reg[r][wp_reg] <= Z.G[r][j_reg];
                        for (int r = 0; r < NCMAX; r++) a_reg[r][wp_reg] <= Z.A[r][j_reg];
                        wp_reg <= wp_reg + PW_G'(1);
                    end
                    j_reg <= j_reg + PW_G'(1);
                end
                ROW: begin
                    if (row_zero) begin
                        if (!b_zero) empty_reg <= 1'b1;
                    end else begin
                        for (int k = 0; k < NGMAX; k++) a_reg[rp_reg][k] <= a_reg[i_reg][k];
                        b_reg[rp_reg] <= Z.b[i_reg];
                        rp_reg        <= rp_reg + PW_C'(1);
                    end
                    i_reg <= i_reg + PW_C'(1);
                end
                default: ;
            endcase
        end
    end

    // Everything outside the packed extent reads as zero, which also gives the reset view
    generate
        for (gi = 0; gi < NMAX; gi++) begin : g_out_gc
            assign OUT.c[gi] = c_reg[gi];
            for (gj = 0; gj < NGMAX; gj++) begin : g_col
                assign OUT.G[gi][gj] = (PW_G'(gj) < wp_reg) ? g_reg[gi][gj] : '0;
            end
        end
        for (gi = 0; gi < NCMAX; gi++) begin : g_out_ab
            assign OUT.b[gi] = (PW_C'(gi) < rp_reg) ? b_reg[gi] : '0;
            for (gj = 0; gj < NGMAX; gj++) begin : g_col
                assign OUT.A[gi][gj] = ((PW_C'(gi) < rp_reg) && (PW_G'(gj) < wp_reg))
                                       ? a_reg[gi][gj] : '0;
            end
        end
    endgenerate

    assign OUT.n  = n_reg;
    assign OUT.ng = wp_reg;
    assign OUT.nc = rp_reg;
    assign empty_o = empty_reg;

endmodule

// File: tb/tb_czonotope_prune.sv
// Directed-vector bench for czonotope_prune: reset, compaction of columns/rows,
// infeasible rows, degenerate sizes and start-while-busy.
module tb_czonotope_prune;
    import czonotope_pkg::*;

    logic clk_i   = 1'b0;
    logic rstn_i  = 1'b0;
    logic start_i = 1'b0;
    logic busy_o, valid_o, empty_o;

    czonotope_if z_if ();
    czonotope_if out_if ();

    czonotope_prune dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .start_i (start_i),
        .Z       (z_if),
        .OUT     (out_if),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .empty_o (empty_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic clear_z();
        for (int r = 0; r < NMAX; r++) begin
            z_if.c[r] = '0;
            for (int k = 0; k < NGMAX; k++) z_if.G[r][k] = '0;
        end
        for (int r = 0; r < NCMAX; r++) begin
            z_if.b[r] = '0;
            for (int k = 0; k < NGMAX; k++) z_if.A[r][k] = '0;
        end
        z_if.n  = '0;
        z_if.ng = '0;
        z_if.nc = '0;
    endtask

    task automatic out_or(output logic [31:0] acc);
        acc = '0;
        for (int r = 0; r < NMAX; r++) begin
            acc |= out_if.c[r];
            for (int k = 0; k < NGMAX; k++) acc |= out_if.G[r][k];
        end
        for (int r = 0; r < NCMAX; r++) begin
            acc |= out_if.b[r];
            for (int k = 0; k < NGMAX; k++) acc |= out_if.A[r][k];
        end
        acc |= {26'd0, out_if.n, out_if.ng};
        acc |= {28'd0, out_if.nc};
    endtask

    // Start pulse on the next negedge; returns the cycle of valid_o (0 = timed out)
    task automatic do_run(output int lat);
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (valid_o) begin
                lat = k;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic load_dead_cols();
        clear_z();
        z_if.n  = 2'd3;
        z_if.ng = 4'd4;
        z_if.nc = 4'd2;
        z_if.c[0] = 32'h3F000000;
        z_if.c[1] = 32'hBF000000;
        z_if.c[2] = 32'h40E00000;
        z_if.G[0][0] = 32'h3F800000;
        z_if.G[2][1] = 32'h80000000;
        z_if.G[1][2] = 32'h40400000;
        z_if.G[0][5] = 32'h3F800000;
        z_if.A[0][0] = 32'h40A00000;
        z_if.A[1][2] = 32'h40800000;
        z_if.A[2][3] = 32'h3F800000;
        z_if.b[0] = 32'h3F800000;
        z_if.b[1] = 32'h40000000;
    endtask

    initial begin
        int          lat;
        int          vcnt;
        int          first_v;
        logic [31:0] acc;

        clear_z();
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        out_or(acc);
        check("rst_out_zero", acc, 32'h0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_empty", {31'd0, empty_o}, 32'd0);

        // Reset mid-COL aborts the run
        load_dead_cols();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        out_or(acc);
        check("abort_out_zero", acc, 32'h0);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (valid_o) vcnt++;
            @(negedge clk_i);
        end
        check("abort_no_valid", vcnt, 32'd0);

        // Dead columns (run after the abort)
        do_run(lat);
        check("cols_lat", lat, 32'd7);
        check("cols_ng", {28'd0, out_if.ng}, 32'd2);
        check("cols_nc", {28'd0, out_if.nc}, 32'd2);
        check("cols_G00", out_if.G[0][0], 32'h3F800000);
        check("cols_G11", out_if.G[1][1], 32'h40400000);
        check("cols_G21", out_if.G[2][1], 32'h0);
        check("cols_G02", out_if.G[0][2], 32'h0);
        check("cols_A00", out_if.A[0][0], 32'h40A00000);
        check("cols_A11", out_if.A[1][1], 32'h40800000);
        check("cols_A01", out_if.A[0][1], 32'h0);
        check("cols_b1", out_if.b[1], 32'h40000000);
        check("cols_c2", out_if.c[2], 32'h40E00000);
        check("cols_empty", {31'd0, empty_o}, 32'd0);

        // No zeros: output mirrors input
        clear_z();
        z_if.n  = 2'd2;
        z_if.ng = 4'd3;
        z_if.nc = 4'd1;
        z_if.c[0] = 32'h41000000;
        z_if.c[1] = 32'h41100000;
        z_if.c[2] = 32'h41200000;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 3; k++) z_if.G[r][k] = 32'h3F800000;
        for (int k = 0; k < 3; k++) z_if.A[0][k] = 32'h3F800000;
        z_if.b[0] = 32'h40000000;
        do_run(lat);
        check("full_lat", lat, 32'd5);
        check("full_n", {30'd0, out_if.n}, 32'd2);
        check("full_ng", {28'd0, out_if.ng}, 32'd3);
        check("full_nc", {28'd0, out_if.nc}, 32'd1);
        check("full_G12", out_if.G[1][2], 32'h3F800000);
        check("full_A02", out_if.A[0][2], 32'h3F800000);
        check("full_b0", out_if.b[0], 32'h40000000);
        check("full_c0", out_if.c[0], 32'h41000000);
        check("full_c2_masked", out_if.c[2], 32'h0);
        check("full_empty", {31'd0, empty_o}, 32'd0);

        // Dead and infeasible rows
        clear_z();
        z_if.n  = 2'd1;
        z_if.ng = 4'd2;
        z_if.nc = 4'd3;
        z_if.G[0][0] = 32'h3F800000;
        z_if.G[0][1] = 32'h40000000;
        z_if.A[0][0] = 32'h80000000;
        z_if.A[1][1] = 32'h40400000;
        z_if.b[1] = 32'h40800000;
        z_if.b[2] = 32'h3F800000;
        do_run(lat);
        check("rows_lat", lat, 32'd6);
        check("rows_ng", {28'd0, out_if.ng}, 32'd2);
        check("rows_nc", {28'd0, out_if.nc}, 32'd1);
        check("rows_A00", out_if.A[0][0], 32'h0);
        check("rows_A01", out_if.A[0][1], 32'h40400000);
        check("rows_A11", out_if.A[1][1], 32'h0);
        check("rows_b0", out_if.b[0], 32'h40800000);
        check("rows_b2", out_if.b[2], 32'h0);
        check("rows_empty", {31'd0, empty_o}, 32'd1);
        @(negedge clk_i);
        check("rows_empty_sticky", {31'd0, empty_o}, 32'd1);

        // Degenerate sizes
        clear_z();
        z_if.n  = 2'd3;
        z_if.c[0] = 32'h3F800000;
        z_if.c[1] = 32'h80000000;
        z_if.c[2] = 32'hC0000000;
        do_run(lat);
        check("degen_lat", lat, 32'd1);
        check("degen_c0", out_if.c[0], 32'h3F800000);
        check("degen_c1", out_if.c[1], 32'h80000000);
        check("degen_c2", out_if.c[2], 32'hC0000000);
        check("degen_ng", {28'd0, out_if.ng}, 32'd0);
        check("degen_nc", {28'd0, out_if.nc}, 32'd0);
        check("degen_empty_cleared", {31'd0, empty_o}, 32'd0);

        // Second start while busy is ignored
        load_dead_cols();
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        vcnt    = 0;
        first_v = 0;
        for (int k = 1; k <= 15; k++) begin
            start_i = (k == 2);
            if (valid_o) begin
                vcnt++;
                if (first_v == 0) first_v = k;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        check("busy_valid_count", vcnt, 32'd1);
        check("busy_valid_cycle", first_v, 32'd7);
        check("busy_ng", {28'd0, out_if.ng}, 32'd2);
        do_run(lat);
        check("busy_next_lat", lat, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/czonotope_prune.md
# czonotope_prune

Post-intersection compaction stage for constrained zonotopes. The upstream intersection stage zero-pads and concatenates generators and constraints, so its output carries dead generator columns and trivially satisfied constraint rows. This block sits directly downstream of that stage and removes all-zero generator columns and all-zero constraint rows. It repacks the result into a dense `CZonotope`, updates `ng`/`nc`, and flags infeasible constraint rows.

## Interface
- `NMAX`, 3, maximum state dimension
- `NGMAX`, 15, maximum generators
- `NCMAX`, 12, maximum constraints
- `DATA_WIDTH`, 32, IEEE-754 single word width
- `clk_i`  in  1  clock
- `rstn_i`  in  1  reset; synchronous, active-low
- `start_i`  in  1  one-cycle request, sampled only in IDLE
- `Z`  in  `CZonotope` interface  source set; held stable from start until `valid_o`
- `OUT`  out  `CZonotope` interface  compacted set (`c`, `G`, `A`, `b`, `n`, `ng`, `nc`)
- `busy_o`  out  1  high from the cycle after start until `valid_o` inclusive
- `valid_o`  out  1  one-cycle pulse; OUT is complete in this cycle
- `empty_o`  out  1  sticky until next start; set if a row has zero A and nonzero b

## Operation
- Zero test for a word: `w[DATA_WIDTH-2:0]==0`. Both +0 and -0 count as zero; the sign bit is ignored.
- FSM states: IDLE, COL, ROW, DONE.
- IDLE, with `start_i`=1:
  - Latch `n`, `ng`, `nc` from Z.
  - Copy `Z.c` to `OUT.c`, zeroing entries `i>=n`.
  - Clear the column and row write pointers `wp` and `rp`, and clear `empty_o`.
  - Go to COL if `ng>0`; else ROW if `nc>0`; else DONE.
- COL, one source column `j` per cycle, `j`=0..ng-1:
  - Column is dead iff `G[i][j]` is zero for all `i<n` and `A[i][j]` is zero for all `i<nc`.
  - Live column: write `G[*][j]` to `OUT.G[*][wp]` and `A[*][j]` to `OUT.A[*][wp]` for all rows, then `wp++`.
  - Dead column: nothing is written.
  - After `j=ng-1`, go to ROW if `nc>0`, else DONE.
- ROW, one row `i` per cycle, `i`=0..nc-1, operating on the already compacted OUT.A (columns `<wp`):
  - Row `A` zero and `Z.b[i]` zero: drop the row.
  - Row `A` zero and `Z.b[i]` nonzero: drop the row and set `empty_o`.
  - Otherwise: copy `OUT.A[i][*]` to `OUT.A[rp][*]` and `Z.b[i]` to `OUT.b[rp]`, then `rp++`.
  - In-place copy is safe because `rp<=i` always holds.
- DONE:
  - Set `OUT.ng=wp` and `OUT.nc=rp`.
  - Zero `OUT.G`/`OUT.A` columns `>=wp`, `OUT.A` rows `>=rp`, and `OUT.b[>=rp]`.
  - Pulse `valid_o` and return to IDLE.
- `OUT.n` equals the latched `n` from start onward.
- No arithmetic is performed. Pointers are `$clog2(NGMAX+1)` and `$clog2(NCMAX+1)` bits wide and can never exceed the latched `ng`/`nc`.

## Timing
- Reset (`rstn_i`=0 at a clock edge) values:
  - State IDLE.
  - All OUT arrays zero; `OUT.n`/`ng`/`nc` = 0.
  - `busy_o`, `valid_o`, `empty_o` = 0.
- Reset during COL/ROW aborts the operation: no `valid_o`, and outputs return to the reset values on the next edge.
- Latency: `start_i` is sampled at edge 0 and `valid_o` is high in cycle `ng+nc+1`.
  - Example: `ng=0`, `nc=0` gives `valid_o` in cycle 1.
- `start_i` while `busy_o`=1 is ignored (no queueing).
- `start_i` in the DONE cycle is ignored. A new start is accepted from the next IDLE cycle, so back-to-back throughput is one set per `ng+nc+2` cycles.
- OUT contents are valid only when `valid_o` is high and remain stable until the next accepted start.

## Structure
- `czonotope_pkg`:
  - state enum `prune_state_t`
  - `function is_fp_zero(logic [DATA_WIDTH-1:0])`
  - pointer-width localparams derived from NGMAX/NCMAX
- No sub-module: column/row zero reduction is a package function applied over loops, and the FSM plus copy datapath stays in one module (~200 lines).

## Test plan
- Reset values: drive `rstn_i`=0 for 2 cycles mid-COL -> OUT all zero, `busy_o`=0, no `valid_o`; a following start completes normally.
- No zeros: `n=2`, `ng=3`, `nc=1`, all G/A entries 0x3F800000, `b`=0x40000000 -> OUT identical to Z, `ng=3`, `nc=1`, `valid_o` in cycle 5, `empty_o`=0.
- Dead columns: `ng=4` with columns 1 and 3 all zero (one entry 0x80000000) and `nc=2` -> `OUT.ng=2`, `OUT.G` cols 0/1 = source cols 0/2, cols 2/3 zero, `valid_o` in cycle 7.
- Dead and infeasible rows: `nc=3`; row 0 is zero A with zero b, row 1 is live, row 2 is zero A with `b`=0x3F800000 -> `OUT.nc=1`, `OUT.b[0]`=source `b[1]`, `empty_o`=1.
- Degenerate sizes: `ng=0`, `nc=0`, `n=3` -> `valid_o` in cycle 1, `OUT.c`=`Z.c`, `OUT.ng`=`OUT.nc`=0.
- Start during busy: second `start_i` pulse in cycle 2 of an `ng=4`, `nc=2` run -> ignored; exactly one `valid_o` in cycle 7, then the next start is accepted.
